// File: rtl/morse_pkg.sv
// Shared types and default constants for the Morse key front-end.
package morse_pkg;

  typedef enum logic [2:0] {IDLE, PRESS, GAP, LGAP, WGAP} seqState_t;

  localparam int unsigned UNIT_W = 8;

  localparam int unsigned DEF_TICK_DIV     = 1000;
  localparam int unsigned DEF_DEBOUNCE     = 16;
  localparam int unsigned DEF_DASH_UNITS   = 2;
  localparam int unsigned DEF_LETTER_UNITS = 3;
  localparam int unsigned DEF_WORD_UNITS   = 7;
  localparam int unsigned DEF_ENTER_UNITS  = 15;

  // Each symbol occupies two bits of the 10-bit encoded character.
  localparam int unsigned SYM_W       = 2;
  localparam int unsigned SEQ_W       = 10;
  localparam int unsigned DEF_MAX_SYM = SEQ_W / SYM_W;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stability counter; emits the debounced level
// and single-cycle pulses aligned with each level change.
module key_debouncer #(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic keyRaw,
  output logic keyLevel,
  output logic keyRise,
  output logic keyFall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] stableCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      stableCnt <= '0;
      keyLevel  <= 1'b0;
      keyRise   <= 1'b0;
      keyFall   <= 1'b0;
    end else begin
      sync1   <= keyRaw;
      sync2   <= sync1;
      keyRise <= 1'b0;
      keyFall <= 1'b0;
      if (sync2 == keyLevel) begin
        stableCnt <= '0;
      end else if (stableCnt == CNT_W'(DEBOUNCE - 1)) begin
        keyLevel  <= sync2;
        stableCnt <= '0;
        keyRise   <= sync2;
        keyFall   <= ~sync2;
      end else begin
        stableCnt <= stableCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/morse_key_sequencer.sv
// Turns a raw telegraph key into Dot/Dash/Space/EndSeq/Enter/Clear strobes
// by timing debounced key-down and key-up intervals in Morse time units.
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned DEBOUNCE     = DEF_DEBOUNCE,
  parameter int unsigned DASH_UNITS   = DEF_DASH_UNITS,
  parameter int unsigned LETTER_UNITS = DEF_LETTER_UNITS,
  parameter int unsigned WORD_UNITS   = DEF_WORD_UNITS,
  parameter int unsigned ENTER_UNITS  = DEF_ENTER_UNITS,
  parameter int unsigned MAX_SYM      = DEF_MAX_SYM
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Key,
  input  logic       ClearReq,
  output logic       Dot,
  output logic       Dash,
  output logic       Space,
  output logic       EndSeq,
  output logic       Enter,
  output logic       Clear,
  output logic [2:0] SymCnt,
  output logic       SymOverflow,
  output logic       KeyDown
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);

  logic              keyRise, keyFall;
  logic              clearQ, clearEdge;
  logic [DIV_W-1:0]  divCnt;
  logic [UNIT_W-1:0] units;
  logic              divWrap, unitStep;
  logic              letterHit, wordHit, enterHit;
  seqState_t         state;

  key_debouncer #(.DEBOUNCE(DEBOUNCE)) uDebouncer (
    .clk     (Clk),
    .rst     (Reset),
    .keyRaw  (Key),
    .keyLevel(KeyDown),
    .keyRise (keyRise),
    .keyFall (keyFall)
  );

  assign clearEdge = ClearReq & ~clearQ;
  assign divWrap   = (divCnt == DIV_W'(TICK_DIV - 1));
  assign unitStep  = divWrap && (units != '1);

  // Thresholds fire only on the step into the threshold value, so each is one-shot.
  assign letterHit = unitStep && (units == UNIT_W'(LETTER_UNITS - 1));
  assign wordHit   = unitStep && (units == UNIT_W'(WORD_UNITS - 1));
  assign enterHit  = unitStep && (units == UNIT_W'(ENTER_UNITS - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      divCnt <= '0;
      units  <= '0;
    end else if (keyRise || keyFall || clearEdge) begin
      divCnt <= '0;
      units  <= '0;
    end else begin
      divCnt <= divWrap ? '0 : divCnt + DIV_W'(1);
      if (unitStep) units <= units + UNIT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      clearQ      <= 1'b0;
      Dot         <= 1'b0;
      Dash        <= 1'b0;
      Space       <= 1'b0;
      EndSeq      <= 1'b0;
      Enter       <= 1'b0;
      Clear       <= 1'b0;
      SymCnt      <= '0;
      SymOverflow <= 1'b0;
    end else begin
      clearQ <= ClearReq;
      Dot    <= 1'b0;
      Dash   <= 1'b0;
      Space  <= 1'b0;
      EndSeq <= 1'b0;
      Enter  <= 1'b0;
      Clear  <= 1'b0;
      if (clearEdge) begin
        Clear       <= 1'b1;
        state       <= IDLE;
        SymCnt      <= '0;
        SymOverflow <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (keyRise) state <= PRESS;
          PRESS: begin
            if (keyFall) begin
              if (SymCnt < 3'(MAX_SYM)) begin
                if (units < UNIT_W'(DASH_UNITS)) Dot <= 1'b1;
                else Dash <= 1'b1;
                SymCnt <= SymCnt + 3'd1;
              end else begin
                SymOverflow <= 1'b1;
              end
              state <= GAP;
            end
          end
          // In the gap states a same-cycle rise overrides the next-state but keeps the strobe.
          GAP: begin
            if (letterHit) begin
              Space       <= 1'b1;
              SymCnt      <= '0;
              SymOverflow <= 1'b0;
              state       <= LGAP;
            end
            if (keyRise) state <= PRESS;
          end
          LGAP: begin
            if (wordHit) begin
              EndSeq <= 1'b1;
              state  <= WGAP;
            end
            if (keyRise) state <= PRESS;
          end
          WGAP: begin
            if (enterHit) begin
              Enter <= 1'b1;
              state <= IDLE;
            end
            if (keyRise) state <= PRESS;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Randomised and directed bench comparing the key sequencer against a
// cycle-level behavioural model built from elapsed-cycle arithmetic.
module tb_morse_key_sequencer;

  localparam int unsigned TD = 4, DB = 2, DASHU = 2, LETU = 3, WORDU = 7, ENTU = 15, MAXS = 5;

  logic       Clk = 1'b0;
  logic       Reset, Key, ClearReq;
  logic       Dot, Dash, Space, EndSeq, Enter, Clear, SymOverflow, KeyDown;
  logic [2:0] SymCnt;

  morse_key_sequencer #(
    .TICK_DIV(TD), .DEBOUNCE(DB), .DASH_UNITS(DASHU), .LETTER_UNITS(LETU),
    .WORD_UNITS(WORDU), .ENTER_UNITS(ENTU), .MAX_SYM(MAXS)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Key(Key), .ClearReq(ClearReq),
    .Dot(Dot), .Dash(Dash), .Space(Space), .EndSeq(EndSeq), .Enter(Enter),
    .Clear(Clear), .SymCnt(SymCnt), .SymOverflow(SymOverflow), .KeyDown(KeyDown)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;

  // Model state: stage 0 idle, 1 key held, 2..4 successive gap stages.
  int mStage, mRun, mElapsed, mSym, mUnits;
  bit mS1, mS2, mLevel, mRise, mFall, mPrevClr, mOvf, mClrEdge;
  bit eDot, eDash, eSpace, eEnd, eEnter, eClear;

  function automatic int gapLimit(input int stage);
    case (stage)
      2:       return LETU * TD;
      3:       return WORDU * TD;
      default: return ENTU * TD;
    endcase
  endfunction

  task automatic modelReset();
    mStage = 0; mRun = 0; mElapsed = 0; mSym = 0;
    mS1 = 0; mS2 = 0; mLevel = 0; mRise = 0; mFall = 0; mPrevClr = 0; mOvf = 0;
    {eDot, eDash, eSpace, eEnd, eEnter, eClear} = '0;
  endtask

  task automatic modelStep();
    mClrEdge = ClearReq && !mPrevClr;
    mUnits = (mElapsed / TD > 255) ? 255 : mElapsed / TD;
    {eDot, eDash, eSpace, eEnd, eEnter, eClear} = '0;
    if (mClrEdge) begin
      eClear = 1; mStage = 0; mSym = 0; mOvf = 0;
    end else if (mStage == 1) begin
      if (mFall) begin
        if (mSym < MAXS) begin
          if (mUnits < DASHU) eDot = 1; else eDash = 1;
          mSym++;
        end else mOvf = 1;
        mStage = 2;
      end
    end else if (mStage >= 2) begin
      if (mElapsed + 1 == gapLimit(mStage)) begin
        case (mStage)
          2: begin eSpace = 1; mSym = 0; mOvf = 0; end
          3: eEnd = 1;
          default: eEnter = 1;
        endcase
        mStage = (mStage == 4) ? 0 : mStage + 1;
      end
      if (mRise) mStage = 1;
    end else if (mRise) mStage = 1;

    if (mRise || mFall || mClrEdge) mElapsed = 0;
    else if (mElapsed < 1000000) mElapsed++;

    mRise = 0; mFall = 0;
    if (mS2 != mLevel) begin
      if (mRun + 1 == DB) begin
        mLevel = mS2; mRun = 0; mRise = mS2; mFall = !mS2;
      end else mRun++;
    end else mRun = 0;
    mS2 = mS1; mS1 = Key;
    mPrevClr = ClearReq;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) modelReset(); else modelStep();
    end
  end

  int nDot = 0, nDash = 0, nSpace = 0, nEnd = 0, nEnter = 0, nClear = 0;
  int prevSym = 0, symBeforeSpace = -1;
  logic [10:0] act, exp;

  initial forever begin
    @(negedge Clk);
    if (!Reset) begin
      act = {Dot, Dash, Space, EndSeq, Enter, Clear, SymCnt, SymOverflow, KeyDown};
      exp = {eDot, eDash, eSpace, eEnd, eEnter, eClear, 3'(mSym), mOvf, mLevel};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model t=%0t: got %b expected %b (Dot Dash Space EndSeq Enter Clear SymCnt Ovf KeyDown)",
                 $time, act, exp);
      end
      checks++;
      if ($countones({Dot, Dash, Space, EndSeq, Enter, Clear}) > 1) begin
        errors++;
        $display("FAIL onehot t=%0t: got strobes %b expected at most one set", $time, act[10:5]);
      end
      nDot += int'(Dot); nDash += int'(Dash); nSpace += int'(Space);
      nEnd += int'(EndSeq); nEnter += int'(Enter); nClear += int'(Clear);
      if (Space) symBeforeSpace = prevSym;
      prevSym = int'(SymCnt);
    end
  end

  task automatic checkLit(input string nm, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, actual, required);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic press(input int hold, input int gap);
    Key = 1'b1; cyc(hold);
    Key = 1'b0; cyc(gap);
  endtask

  int d0, d1, d2, d3, d4, d5, total0, gapLen, pressLen, clrAt;

  initial begin
    Reset = 1'b1; Key = 1'b0; ClearReq = 1'b0;
    #1;
    checkLit("reset_strobes", int'({Dot, Dash, Space, EndSeq, Enter, Clear}), 0);
    checkLit("reset_symcnt", int'(SymCnt), 0);
    checkLit("reset_flags", int'({SymOverflow, KeyDown}), 0);
    cyc(3);
    Reset = 1'b0;
    cyc(5);

    // 1: single dot followed by a full idle gap
    d0 = nDot; d1 = nSpace; d2 = nEnd; d3 = nEnter;
    press(6, 8);
    checkLit("t1_symcnt_after_dot", int'(SymCnt), 1);
    cyc(70);
    checkLit("t1_dots", nDot - d0, 1);
    checkLit("t1_spaces", nSpace - d1, 1);
    checkLit("t1_endseq", nEnd - d2, 1);
    checkLit("t1_enter", nEnter - d3, 1);
    checkLit("t1_symcnt_end", int'(SymCnt), 0);

    // 2: dash then dot within one character
    d0 = nDot; d1 = nDash; d2 = nSpace;
    press(12, 4);
    press(4, 80);
    checkLit("t2_dots", nDot - d0, 1);
    checkLit("t2_dashes", nDash - d1, 1);
    checkLit("t2_spaces", nSpace - d2, 1);
    checkLit("t2_symcnt_at_space", symBeforeSpace, 2);

    // 3: six dots overflow the character
    d0 = nDot; d1 = nSpace;
    for (int i = 0; i < 5; i++) press(4, 4);
    press(4, 8);
    checkLit("t3_dots", nDot - d0, 5);
    checkLit("t3_overflow_set", int'(SymOverflow), 1);
    cyc(80);
    checkLit("t3_overflow_cleared", int'(SymOverflow), 0);
    checkLit("t3_spaces", nSpace - d1, 1);

    // 4: single-cycle glitch is filtered
    total0 = nDot + nDash + nSpace + nEnd + nEnter + nClear;
    press(1, 20);
    checkLit("t4_keydown", int'(KeyDown), 0);
    checkLit("t4_strobes", nDot + nDash + nSpace + nEnd + nEnter + nClear - total0, 0);

    // 5: clear during a held press discards it
    d0 = nDot + nDash; d1 = nClear;
    Key = 1'b1; cyc(10);
    ClearReq = 1'b1; cyc(1);
    ClearReq = 1'b0; cyc(5);
    Key = 1'b0; cyc(80);
    checkLit("t5_clear", nClear - d1, 1);
    checkLit("t5_symbols", nDot + nDash - d0, 0);
    checkLit("t5_symcnt", int'(SymCnt), 0);

    // 6: asynchronous reset in the middle of a press
    total0 = nDot + nDash + nSpace + nEnd + nEnter + nClear;
    Key = 1'b1; cyc(8);
    #3 Reset = 1'b1;
    #1;
    checkLit("t6_reset_strobes", int'({Dot, Dash, Space, EndSeq, Enter, Clear}), 0);
    checkLit("t6_reset_keydown", int'(KeyDown), 0);
    Key = 1'b0;
    @(posedge Clk); #3 Reset = 1'b0;
    cyc(80);
    checkLit("t6_no_strobes", nDot + nDash + nSpace + nEnd + nEnter + nClear - total0, 0);

    // Randomised traffic, model-checked every cycle
    for (int i = 0; i < 40; i++) begin
      pressLen = $urandom_range(1, 20);
      case ($urandom_range(0, 3))
        0: gapLen = $urandom_range(1, 6);
        1: gapLen = $urandom_range(10, 14);
        2: gapLen = $urandom_range(26, 32);
        default: gapLen = $urandom_range(58, 66);
      endcase
      Key = 1'b1; cyc(pressLen);
      Key = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        clrAt = $urandom_range(0, gapLen);
        cyc(clrAt);
        ClearReq = 1'b1; cyc(1);
        ClearReq = 1'b0; cyc(gapLen - clrAt);
      end else cyc(gapLen);
    end
    cyc(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
